ps2_keyboard: RTL and testbench
===============================

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 Parameter TIMEOUT, default 50000, SHALL set the idle clk cycles allowed between PS/2 falling edges inside a frame before the frame is abandoned.
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 ps2_clk  input  1  SHALL be the asynchronous PS/2 clock line from the keyboard.
REQ-005 ps2_data  input  1  SHALL be the asynchronous PS/2 data line from the keyboard.
REQ-006 key_code  output  16  SHALL hold the Hack code of the currently pressed key, 0 when none; this is the CPU-read memory-mapped keyboard word.
REQ-007 scan_byte  output  8  SHALL hold the last correctly received raw scan byte.
REQ-008 scan_strobe  output  1  SHALL pulse high for one cycle when scan_byte is updated.
REQ-009 frame_error  output  1  SHALL pulse high for one cycle when a frame is discarded.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is synced clock high in the previous cycle and low now.
REQ-011 Data SHALL be sampled only on a detected falling edge; frame = start(0), 8 data LSB first, odd parity, stop(1).
REQ-012 States SHALL be IDLE and RECEIVE; IDLE->RECEIVE on a falling edge sampling 0; a falling edge sampling 1 in IDLE SHALL be ignored without error.
REQ-013 In RECEIVE a 4-bit counter SHALL count sampled bits; after the 11th (stop) bit the FSM SHALL return to IDLE.
REQ-014 Frame check on stop bit: parity over 8 data bits plus parity bit odd and stop bit 1; on pass, in the cycle after the stop-bit edge, scan_byte SHALL update and scan_strobe pulse.
REQ-015 On parity or stop failure, frame_error SHALL pulse in the cycle after the stop-bit edge, scan_byte/scan_strobe unchanged, and break/extended flags cleared.
REQ-016 In RECEIVE, a 16-bit idle counter SHALL reset on every falling edge; on reaching TIMEOUT the FSM SHALL return to IDLE, pulse frame_error, clear flags.
REQ-017 Decoder: byte E0 SHALL set extended flag; F0 SHALL set break flag; neither alters key_code.
REQ-018 Any other valid byte SHALL be looked up with the extended flag, then both flags SHALL clear in the same cycle.
REQ-019 Mapping, non-extended (hex scan -> decimal Hack): A1C B32 C21 D23 E24 F2B G34 H33 I43 J3B K42 L4B M3A N31 O44 P4D Q15 R2D S1B T2C U3C V2A W1D X22 Y35 Z1A -> 65..90 alphabetical; 0:45 1:16 2:1E 3:26 4:25 5:2E 6:36 7:3D 8:3E 9:46 -> 48..57; space 29->32; enter 5A->128; backspace 66->129; esc 76->140.
REQ-020 Mapping, extended: 6B->130 (left), 75->131 (up), 74->132 (right), 72->133 (down).
REQ-021 Make of a mapped key SHALL set key_code to its code in the scan_strobe cycle, replacing any previous key.
REQ-022 Break of a mapped key SHALL clear key_code to 0 only if its code equals current key_code; otherwise ignored.
REQ-023 Unmapped make/break codes SHALL leave key_code unchanged; scan_strobe still pulses.
REQ-024 Typematic repeat makes of the held key SHALL leave key_code unchanged.
REQ-025 key_code bits 15:8 SHALL always be 0.

Reset
REQ-026 reset SHALL force IDLE, bit and idle counters 0, flags clear, key_code 0, scan_byte 0x00, scan_strobe 0, frame_error 0 on the next edge.
REQ-027 reset asserted mid-frame SHALL abandon the frame without frame_error; bits after deassertion are taken as a new frame only from a start bit.
REQ-028 Synchronizer flops SHALL reset to 1 (idle bus) so no spurious edge follows reset.

Verification
REQ-029 Frame 0x1C, parity 0, stop 1 -> one scan_strobe, scan_byte=0x1C, key_code=65.
REQ-030 Then F0,1C -> key_code 65 then 0; scan_strobe pulses twice; no frame_error.
REQ-031 E0,75 then E0,F0,75 -> key_code 131 then 0.
REQ-032 Make 1C then make 32, then break 1C -> key_code 65, 66, stays 66; break 32 -> 0.
REQ-033 Frame 0x29 with parity 1 -> frame_error pulse, key_code and scan_byte unchanged; frame with stop 0 -> same.
REQ-034 Start bit plus 4 bits then silence TIMEOUT cycles -> frame_error pulse, FSM IDLE; next full 0x45 frame -> key_code 48.

Source files
------------

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronizes the PS/2 lines, deframes scan bytes
// and decodes make/break/extended sequences into the Hack keyboard word.
module ps2_keyboard #(
    parameter int TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key_code,
    output logic [7:0]  scan_byte,
    output logic        scan_strobe,
    output logic        frame_error
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    typedef enum logic {IDLE, RECEIVE} state_t;

    state_t      state, state_next;
    logic        clk_s1, clk_s2, clk_prev;
    logic        data_s1, data_s2;
    logic        fall;
    logic [3:0]  bit_cnt;
    logic [8:0]  shreg;
    logic [15:0] idle_cnt;
    logic        ext_flag, brk_flag;
    logic [7:0]  key_reg;
    logic        start_frame, shift_bit, stop_edge, timeout;
    logic        frame_ok;
    logic        map_hit;
    logic [7:0]  map_code;

    assign fall     = clk_prev & ~clk_s2;
    // shreg holds {parity, d7..d0} when the stop bit arrives; 9 bits must be odd.
    assign frame_ok = data_s2 & (^shreg);
    assign key_code = {8'h00, key_reg};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        shift_bit   = 1'b0;
        stop_edge   = 1'b0;
        timeout     = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !data_s2) begin
                    state_next  = RECEIVE;
                    start_frame = 1'b1;
                end
            end
            RECEIVE: begin
                if (fall) begin
                    if (bit_cnt == 4'd10) begin
                        state_next = IDLE;
                        stop_edge  = 1'b1;
                    end else begin
                        shift_bit = 1'b1;
                    end
                end else if (idle_cnt == TIMEOUT_CNT) begin
                    state_next = IDLE;
                    timeout    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        map_hit  = 1'b1;
        map_code = 8'd0;
        if (ext_flag) begin
            case (shreg[7:0])
                8'h6B: map_code = 8'd130;
                8'h75: map_code = 8'd131;
                8'h74: map_code = 8'd132;
                8'h72: map_code = 8'd133;
                default: map_hit = 1'b0;
            endcase
        end else begin
            case (shreg[7:0])
                8'h1C: map_code = 8'd65;  8'h32: map_code = 8'd66;  8'h21: map_code = 8'd67;
                8'h23: map_code = 8'd68;  8'h24: map_code = 8'd69;  8'h2B: map_code = 8'd70;
                8'h34: map_code = 8'd71;  8'h33: map_code = 8'd72;  8'h43: map_code = 8'd73;
                8'h3B: map_code = 8'd74;  8'h42: map_code = 8'd75;  8'h4B: map_code = 8'd76;
                8'h3A: map_code = 8'd77;  8'h31: map_code = 8'd78;  8'h44: map_code = 8'd79;
                8'h4D: map_code = 8'd80;  8'h15: map_code = 8'd81;  8'h2D: map_code = 8'd82;
                8'h1B: map_code = 8'd83;  8'h2C: map_code = 8'd84;  8'h3C: map_code = 8'd85;
                8'h2A: map_code = 8'd86;  8'h1D: map_code = 8'd87;  8'h22: map_code = 8'd88;
                8'h35: map_code = 8'd89;  8'h1A: map_code = 8'd90;
                8'h45: map_code = 8'd48;  8'h16: map_code = 8'd49;  8'h1E: map_code = 8'd50;
                8'h26: map_code = 8'd51;  8'h25: map_code = 8'd52;  8'h2E: map_code = 8'd53;
                8'h36: map_code = 8'd54;  8'h3D: map_code = 8'd55;  8'h3E: map_code = 8'd56;
                8'h46: map_code = 8'd57;
                8'h29: map_code = 8'd32;  8'h5A: map_code = 8'd128; 8'h66: map_code = 8'd129;
                8'h76: map_code = 8'd140;
                default: map_hit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1      <= 1'b1;
            clk_s2      <= 1'b1;
            clk_prev    <= 1'b1;
            data_s1     <= 1'b1;
            data_s2     <= 1'b1;
            bit_cnt     <= 4'd0;
            shreg       <= 9'd0;
            idle_cnt    <= 16'd0;
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
            key_reg     <= 8'd0;
            scan_byte   <= 8'h00;
            scan_strobe <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            clk_s1      <= ps2_clk;
            clk_s2      <= clk_s1;
            clk_prev    <= clk_s2;
            data_s1     <= ps2_data;
            data_s2     <= data_s1;
            scan_strobe <= 1'b0;
            frame_error <= 1'b0;

            if (state_next == IDLE) bit_cnt <= 4'd0;
            else if (start_frame)   bit_cnt <= 4'd1;
            else if (shift_bit)     bit_cnt <= bit_cnt + 4'd1;

            if (shift_bit) shreg <= {data_s2, shreg[8:1]};

            if (state == RECEIVE && state_next == RECEIVE && !fall) idle_cnt <= idle_cnt + 16'd1;
            else                                                    idle_cnt <= 16'd0;

            if (stop_edge && frame_ok) begin
                scan_byte   <= shreg[7:0];
                scan_strobe <= 1'b1;
                if (shreg[7:0] == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (shreg[7:0] == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    // A break only releases the key it names; makes always take over.
                    if (map_hit) begin
                        if (!brk_flag)                 key_reg <= map_code;
                        else if (key_reg == map_code)  key_reg <= 8'd0;
                    end
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end
            end

            if ((stop_edge && !frame_ok) || timeout) begin
                frame_error <= 1'b1;
                ext_flag    <= 1'b0;
                brk_flag    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: directed scenarios followed by random scan traffic,
// checked against a table-driven keyboard model.
module tb_ps2_keyboard;

    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key_code;
    logic [7:0]  scan_byte;
    logic        scan_strobe;
    logic        frame_error;

    ps2_keyboard #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_code(key_code), .scan_byte(scan_byte),
        .scan_strobe(scan_strobe), .frame_error(frame_error)
    );

    initial forever #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int         norm_map[256];
    int         ext_map[256];
    logic [7:0] mapped_norm[$];
    logic [7:0] mapped_ext[$];
    bit         m_ext, m_brk;
    int         m_key;
    logic [7:0] m_scan;

    // Pulse monitor
    int         strobe_cnt = 0;
    int         err_cnt    = 0;
    logic [15:0] strobe_key_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (scan_strobe) begin
                strobe_cnt++;
                strobe_key_q.push_back(key_code);
            end
            if (frame_error) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(4);
        ps2_clk = 1'b0;
        wait_cyc(8);
        ps2_clk = 1'b1;
        wait_cyc(4);
    endtask

    function automatic void model_good(input logic [7:0] b);
        int code;
        m_scan = b;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            code = m_ext ? ext_map[b] : norm_map[b];
            if (code >= 0) begin
                if (!m_brk) m_key = code;
                else if (m_key == code) m_key = 0;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    function automatic void model_bad();
        m_ext = 0;
        m_brk = 0;
    endfunction

    // Sends one frame and checks its effect against the model.
    task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string tag);
        int s0, e0;
        logic [15:0] sk;
        s0 = strobe_cnt;
        e0 = err_cnt;
        strobe_key_q.delete();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(~bad_stop);
        ps2_data = 1'b1;
        wait_cyc(2);
        if (bad_par || bad_stop) begin
            model_bad();
            check({tag, "_strobes"}, strobe_cnt - s0, 0);
            check({tag, "_errors"}, err_cnt - e0, 1);
        end else begin
            model_good(b);
            check({tag, "_strobes"}, strobe_cnt - s0, 1);
            check({tag, "_errors"}, err_cnt - e0, 0);
            sk = (strobe_key_q.size() > 0) ? strobe_key_q[0] : 16'hFFFF;
            check({tag, "_key_at_strobe"}, sk, m_key);
        end
        check({tag, "_scan_byte"}, scan_byte, m_scan);
        check({tag, "_key_code"}, key_code, m_key);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        m_ext = 0; m_brk = 0; m_key = 0; m_scan = 8'h00;
        wait_cyc(2);
    endtask

    task automatic init_maps();
        logic [7:0] alpha[26];
        logic [7:0] digit[10];
        logic [7:0] arrows[4];
        alpha  = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                   8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                   8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        digit  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        arrows = '{8'h6B, 8'h75, 8'h74, 8'h72};
        for (int i = 0; i < 256; i++) begin
            norm_map[i] = -1;
            ext_map[i]  = -1;
        end
        for (int i = 0; i < 26; i++) norm_map[alpha[i]] = 65 + i;
        for (int i = 0; i < 10; i++) norm_map[digit[i]] = 48 + i;
        norm_map[8'h29] = 32;
        norm_map[8'h5A] = 128;
        norm_map[8'h66] = 129;
        norm_map[8'h76] = 140;
        for (int i = 0; i < 4; i++) ext_map[arrows[i]] = 130 + i;
        for (int i = 0; i < 256; i++) begin
            if (norm_map[i] >= 0) mapped_norm.push_back(8'(i));
            if (ext_map[i] >= 0)  mapped_ext.push_back(8'(i));
        end
    endtask

    initial begin
        int s0, e0, r;
        logic [7:0] k;
        init_maps();

        // Reset state
        do_reset();
        check("rst_key_code", key_code, 0);
        check("rst_scan_byte", scan_byte, 0);
        check("rst_strobe", scan_strobe, 0);
        check("rst_frame_error", frame_error, 0);

        // Basic make / break
        do_frame(8'h1C, 0, 0, "make_a");
        check("make_a_is_65", key_code, 65);
        do_frame(8'hF0, 0, 0, "brk_a_f0");
        check("f0_keeps_key", key_code, 65);
        do_frame(8'h1C, 0, 0, "brk_a");
        check("brk_a_is_0", key_code, 0);

        // Extended arrow
        do_frame(8'hE0, 0, 0, "up_e0");
        do_frame(8'h75, 0, 0, "up_make");
        check("up_is_131", key_code, 131);
        do_frame(8'hE0, 0, 0, "up_brk_e0");
        do_frame(8'hF0, 0, 0, "up_brk_f0");
        do_frame(8'h75, 0, 0, "up_brk");
        check("up_rel_is_0", key_code, 0);

        // Rollover: stale break ignored
        do_frame(8'h1C, 0, 0, "roll_a");
        do_frame(8'h32, 0, 0, "roll_b");
        check("roll_b_is_66", key_code, 66);
        do_frame(8'hF0, 0, 0, "roll_f0a");
        do_frame(8'h1C, 0, 0, "roll_brk_a");
        check("roll_stays_66", key_code, 66);
        do_frame(8'h32, 0, 0, "typematic_b");
        do_frame(8'hF0, 0, 0, "roll_f0b");
        do_frame(8'h32, 0, 0, "roll_brk_b");
        check("roll_end_0", key_code, 0);

        // Bad frames; the F0 before the bad frame must be forgotten
        do_frame(8'h29, 0, 0, "space");
        do_frame(8'hF0, 0, 0, "pre_bad_f0");
        do_frame(8'h29, 1, 0, "bad_parity");
        do_frame(8'h29, 0, 1, "bad_stop");
        do_frame(8'h5A, 0, 0, "enter_after_bad");
        check("enter_is_128", key_code, 128);

        // Lone falling edge with data high in IDLE is ignored
        s0 = strobe_cnt; e0 = err_cnt;
        send_bit(1'b1);
        wait_cyc(4);
        check("idle_one_strobe", strobe_cnt - s0, 0);
        check("idle_one_err", err_cnt - e0, 0);

        // Timeout mid-frame
        s0 = strobe_cnt; e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        wait_cyc(TO + 20);
        model_bad();
        check("timeout_err", err_cnt - e0, 1);
        check("timeout_strobe", strobe_cnt - s0, 0);
        do_frame(8'h45, 0, 0, "after_timeout");
        check("zero_is_48", key_code, 48);

        // Long but legal gap inside a frame
        s0 = strobe_cnt; e0 = err_cnt;
        k = 8'h76;
        send_bit(1'b0);
        wait_cyc(TO - 40);
        for (int i = 0; i < 8; i++) send_bit(k[i]);
        send_bit(~^k);
        send_bit(1'b1);
        wait_cyc(2);
        model_good(k);
        check("long_gap_strobe", strobe_cnt - s0, 1);
        check("long_gap_err", err_cnt - e0, 0);
        check("esc_is_140", key_code, 140);

        // Reset mid-frame
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        e0 = err_cnt;
        do_reset();
        wait_cyc(TO + 20);
        check("midrst_no_err", err_cnt - e0, 0);
        check("midrst_key", key_code, 0);
        do_frame(8'h1C, 0, 0, "after_midrst");

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            wait_cyc($urandom_range(0, 30));
            if (r == 0) do_frame(8'($urandom_range(0, 255)), 1, 0, "rnd_badpar");
            else if (r == 1) do_frame(8'($urandom_range(0, 255)), 0, 1, "rnd_badstop");
            else if (r == 2) do_frame(8'($urandom_range(0, 255)), 0, 0, "rnd_byte");
            else begin
                bit ext, brk;
                ext = ($urandom_range(0, 3) == 0);
                brk = ($urandom_range(0, 2) == 0);
                k = ext ? mapped_ext[$urandom_range(0, mapped_ext.size() - 1)]
                        : mapped_norm[$urandom_range(0, mapped_norm.size() - 1)];
                if (ext) do_frame(8'hE0, 0, 0, "rnd_e0");
                if (brk) do_frame(8'hF0, 0, 0, "rnd_f0");
                do_frame(k, 0, 0, "rnd_key");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
